sram_bus_master: RTL and testbench

Initiator-side controller for the team's single-port RAM bus. The bus is a shared bidirectional data line with cs/we/oe strobes.
- Accepts read/write requests on a valid/ready interface.
- Sequences addr/cs/we/oe on the RAM pins and drives or releases the shared data bus.
- Returns read data on a one-cycle response strobe.
- Sits between a processor load/store unit and one RAM instance.

---
 rtl/sram_bus_master.sv | 132 +++++++++++++
 tb/tb_sram_bus_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_master.sv
// sram_bus_master: initiator-side sequencer for a synchronous single-port RAM
// sharing one bidirectional data bus. Requests arrive on valid/ready.
// Writes take one bus cycle each and may stream back to back. Reads walk
// RD_ADDR -> RD_DATA -> TURN and return data on a one-cycle rsp_valid pulse.
// Every pin-level output is registered. The value loaded into each output
// register is the one that belongs to the state being entered.
module sram_bus_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_TURN    = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    cs_q, cs_d;
    logic                    we_q, we_d;
    logic                    oe_q, oe_d;
    logic                    drive_q, drive_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Accepting a new request is only safe when no read is in flight.
    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);

    // The master drives the shared bus only while a write is on the pins.
    assign ram_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign ram_addr  = addr_q;
    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_oe    = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next state plus the pin values that belong to that next state.
    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        oe_d        = 1'b0;
        drive_d     = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (req_valid) begin
                    cs_d   = 1'b1;
                    addr_d = req_addr;
                    if (req_we) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        drive_d = 1'b1;
                        wdata_d = req_wdata;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                // Same address stays on the pins; RAM now drives its latched word.
                state_d = ST_RD_DATA;
                cs_d    = 1'b1;
                oe_d    = 1'b1;
            end
            ST_RD_DATA: begin
                // Capture the RAM's word as it leaves; TURN releases the bus.
                state_d     = ST_TURN;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_data;
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            drive_q     <= 1'b0;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            drive_q     <= drive_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_master.sv
// Self-checking bench for sram_bus_master: behavioural RAM on the pins,
// an array/queue reference model, directed scenarios and a random mix.
module tb_sram_bus_master;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int bad_turn = 0;
    logic prev_oe = 1'b0;

    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] mem_model [16];

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t got_q[$];

    sram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: ignores controller reset, as the real part does.
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) ram_q <= ram_mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

    // Pin monitor: records responses and bus-ownership violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) got_q.push_back('{cyc, rsp_rdata});
            if ((ram_cs && ram_we && prev_oe) || (ram_we && ram_oe)) bad_turn <= bad_turn + 1;
            prev_oe <= ram_oe;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and return once it has been accepted (or timed out).
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int waited);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        while (!req_ready && waited < 10) begin
            step();
            waited++;
        end
        step();
        if (we) mem_model[a] = d;
        else exp_q.push_back('{cyc + 2, mem_model[a]});
    endtask

    // Let the pipe empty, then match every expected response against observed ones.
    task automatic drain();
        rsp_t e;
        rsp_t g;
        req_valid = 1'b0;
        repeat (6) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                $display("FAIL rsp_missing: got no response, expected data %h at cycle %0d", e.d, e.c);
                miscompares++;
            end else begin
                g = got_q.pop_front();
                if (g.c !== e.c || g.d !== e.d) begin
                    $display("FAIL rsp_data: got %h at cycle %0d, expected %h at cycle %0d", g.d, g.c, e.d, e.c);
                    miscompares++;
                end
            end
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL rsp_extra: got %h at cycle %0d, expected no response", g.d, g.c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if ({ram_cs, ram_we, ram_oe, rsp_valid, req_ready} !== 5'b00001 || ram_addr !== 4'd0
            || rsp_rdata !== 32'd0) begin
            $display("FAIL reset_state: got cs/we/oe/rv/rdy=%b addr=%h rdata=%h, expected 00001 0 0",
                     {ram_cs, ram_we, ram_oe, rsp_valid, req_ready}, ram_addr, rsp_rdata);
            miscompares++;
        end
    endtask

    task automatic test_write_read();
        int w;
        issue(1'b1, 4'd3, 32'hDEADBEEF, w);
        req_valid = 1'b0;
        vectors++;
        if (w !== 0 || {ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== 4'd3 || ram_data !== 32'hDEADBEEF) begin
            $display("FAIL write_pins: got wait=%0d cs/we/oe=%b addr=%h data=%h, expected 0 110 3 deadbeef",
                     w, {ram_cs, ram_we, ram_oe}, ram_addr, ram_data);
            miscompares++;
        end
        step();
        issue(1'b0, 4'd3, 32'd0, w);
        req_valid = 1'b0;
        vectors++;
        if ({ram_cs, ram_we, ram_oe, req_ready, rsp_valid} !== 5'b10000 || ram_addr !== 4'd3) begin
            $display("FAIL rd_addr_pins: got cs/we/oe/rdy/rv=%b addr=%h, expected 10000 3",
                     {ram_cs, ram_we, ram_oe, req_ready, rsp_valid}, ram_addr);
            miscompares++;
        end
        step();
        vectors++;
        if ({ram_cs, ram_we, ram_oe, req_ready, rsp_valid} !== 5'b10100 || ram_addr !== 4'd3
            || ram_data !== 32'hDEADBEEF) begin
            $display("FAIL rd_data_pins: got cs/we/oe/rdy/rv=%b addr=%h bus=%h, expected 10100 3 deadbeef",
                     {ram_cs, ram_we, ram_oe, req_ready, rsp_valid}, ram_addr, ram_data);
            miscompares++;
        end
        step();
        vectors++;
        if ({ram_cs, ram_we, ram_oe, req_ready, rsp_valid} !== 5'b00001 || rsp_rdata !== 32'hDEADBEEF) begin
            $display("FAIL turn_pins: got cs/we/oe/rdy/rv=%b rdata=%h, expected 00001 deadbeef",
                     {ram_cs, ram_we, ram_oe, req_ready, rsp_valid}, rsp_rdata);
            miscompares++;
        end
        step();
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            $display("FAIL after_turn: got rdy=%b rv=%b rdata=%h, expected 1 0 deadbeef",
                     req_ready, rsp_valid, rsp_rdata);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) begin
            d = 32'h100 + 32'(i);
            issue(1'b1, 4'(i), d, w);
            vectors++;
            if (w !== 0 || ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'(i) || ram_data !== d) begin
                $display("FAIL b2b_write: got wait=%0d cs=%b we=%b addr=%h data=%h, expected 0 1 1 %h %h",
                         w, ram_cs, ram_we, ram_addr, ram_data, 4'(i), d);
                miscompares++;
            end
        end
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 4'(i), 32'd0, w);
            vectors++;
            if (w !== ((i == 0) ? 0 : 3)) begin
                $display("FAIL b2b_read_wait: got %0d cycles, expected %0d", w, (i == 0) ? 0 : 3);
                miscompares++;
            end
        end
        drain();
    endtask

    task automatic test_write_then_read();
        int w;
        issue(1'b1, 4'd7, 32'hA5A5A5A5, w);
        issue(1'b0, 4'd7, 32'd0, w);
        req_valid = 1'b0;
        vectors++;
        if (w !== 0 || {ram_cs, ram_we, ram_oe} !== 3'b100 || ram_addr !== 4'd7) begin
            $display("FAIL wr_rd: got wait=%0d cs/we/oe=%b addr=%h, expected 0 100 7",
                     w, {ram_cs, ram_we, ram_oe}, ram_addr);
            miscompares++;
        end
        drain();
    endtask

    task automatic test_turnaround();
        int w;
        int k;
        int bt0;
        bt0 = bad_turn;
        issue(1'b0, 4'd5, 32'd0, w);
        req_we    = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 32'h12345678;
        k = 0;
        while (!req_ready && k < 10) begin
            vectors++;
            if (ram_we !== 1'b0) begin
                $display("FAIL turn_no_write: got we=%b in cycle A+%0d, expected 0", ram_we, k);
                miscompares++;
            end
            if (k == 2) begin
                vectors++;
                if (ram_oe !== 1'b0 || ram_cs !== 1'b0 || rsp_valid !== 1'b1) begin
                    $display("FAIL turn_state: got oe=%b cs=%b rv=%b, expected 0 0 1", ram_oe, ram_cs, rsp_valid);
                    miscompares++;
                end
            end
            step();
            k++;
        end
        step();
        mem_model[5] = 32'h12345678;
        req_valid = 1'b0;
        vectors++;
        if (k !== 3 || {ram_cs, ram_we, ram_oe} !== 3'b110 || ram_data !== 32'h12345678) begin
            $display("FAIL turn_write: got wait=%0d cs/we/oe=%b data=%h, expected 3 110 12345678",
                     k, {ram_cs, ram_we, ram_oe}, ram_data);
            miscompares++;
        end
        step();
        issue(1'b0, 4'd5, 32'd0, w);
        drain();
        vectors++;
        if (bad_turn !== bt0) begin
            $display("FAIL bus_overlap: got %0d violations, expected 0", bad_turn - bt0);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        int w;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'(i * 3), 32'd0, w);
            vectors++;
            if (w !== ((i == 0) ? 0 : 3) || req_ready !== 1'b0) begin
                $display("FAIL backpressure: got wait=%0d rdy=%b, expected %0d 0", w, req_ready, (i == 0) ? 0 : 3);
                miscompares++;
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        int w;
        issue(1'b0, 4'd9, 32'd0, w);
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(exp_q.pop_back());
        vectors++;
        if ({ram_cs, ram_we, ram_oe, rsp_valid, req_ready} !== 5'b00001 || rsp_rdata !== 32'd0) begin
            $display("FAIL reset_mid_read: got cs/we/oe/rv/rdy=%b rdata=%h, expected 00001 0",
                     {ram_cs, ram_we, ram_oe, rsp_valid, req_ready}, rsp_rdata);
            miscompares++;
        end
        step();
        issue(1'b0, 4'd3, 32'd0, w);
        drain();
        issue(1'b1, 4'd3, 32'hCAFEF00D, w);
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({ram_cs, ram_we} !== 2'b00) begin
            $display("FAIL reset_mid_write: got cs/we=%b, expected 00", {ram_cs, ram_we});
            miscompares++;
        end
        issue(1'b0, 4'd3, 32'd0, w);
        drain();
    endtask

    task automatic test_random();
        int w;
        int bt0;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bt0 = bad_turn;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                step();
            end
            we = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
            issue(we, a, d, w);
            vectors++;
            if (w > 3 || ram_cs !== 1'b1 || ram_we !== we || ram_oe !== 1'b0 || ram_addr !== a
                || (we && ram_data !== d)) begin
                $display("FAIL random_req %0d: got wait=%0d cs/we/oe=%b addr=%h data=%h, expected <=3 1%b0 %h %h",
                         k, w, {ram_cs, ram_we, ram_oe}, ram_addr, ram_data, we, a, d);
                miscompares++;
            end
        end
        drain();
        vectors++;
        if (bad_turn !== bt0) begin
            $display("FAIL random_bus_overlap: got %0d violations, expected 0", bad_turn - bt0);
            miscompares++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i]   = $urandom;
            mem_model[i] = ram_mem[i];
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_write_then_read();
        test_turnaround();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
